// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the 5-stage RV32I pipeline sequencing
// controller: FSM state encoding, the bundle of pipeline enables/flushes,
// the canned enable/flush patterns used by the controller, and the
// load-use hazard detector.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_MEMW = 2'd1,
        S_MDUW = 2'd2
    } ctrl_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // One bundle of every pipeline-register enable, flush and the PC select.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic pc_sel;
    } ctrl_out_t;

    // Everything advances, nothing flushed.
    localparam ctrl_out_t CTRL_GO = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0, pc_sel: 1'b0};

    // Whole pipeline frozen (memory wait state).
    localparam ctrl_out_t CTRL_HOLD = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0, pc_sel: 1'b0};

    // Redirect: take the EX target and squash the two younger instructions.
    localparam ctrl_out_t CTRL_REDIRECT = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b0, pc_sel: 1'b1};

    // MUL/DIV busy: front end and EX frozen, MEM receives bubbles, WB drains.
    localparam ctrl_out_t CTRL_MDU = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b1, pc_sel: 1'b0};

    // Load-use: hold PC and IF/ID, insert one bubble into EX, load moves on.
    localparam ctrl_out_t CTRL_LOAD_USE = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b1, ex_mem_flush: 1'b0, pc_sel: 1'b0};

    // Reset: nothing advances and every stage register is loaded with a bubble.
    localparam ctrl_out_t CTRL_RESET = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0,
        if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b1, pc_sel: 1'b0};

    // A load in EX whose destination is read by the instruction in ID.
    // x0 is never a real dependency.
    function automatic logic load_use_hazard(
        input logic       ex_is_load,
        input logic [4:0] ex_rd,
        input logic [4:0] id_rs1,
        input logic [4:0] id_rs2,
        input logic       id_use_rs1,
        input logic       id_use_rs2
    );
        logic hit_s;
        hit_s = (id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd));
        return ex_is_load && (ex_rd != REG_ZERO) && hit_s;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
// Hazard inputs from the pipeline stages and the enable/flush/redirect
// controls returned to them.
//   master : pipeline side (drives hazard status, receives controls)
//   slave  : pipe_ctrl side (receives hazard status, drives controls)
// -----------------------------------------------------------------------------
interface pipe_ctrl_if;

    // Hazard status
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       ex_is_load;
    logic [4:0] ex_rd;
    logic       ex_redirect;
    logic       ex_mdu_start;
    logic       mdu_done;
    logic       mem_req;
    logic       mem_ack;

    // Pipeline controls
    logic       pc_en;
    logic       if_id_en;
    logic       id_ex_en;
    logic       ex_mem_en;
    logic       mem_wb_en;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_flush;
    logic       pc_sel;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_is_load, ex_rd,
               ex_redirect, ex_mdu_start, mdu_done, mem_req, mem_ack,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, pc_sel
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_is_load, ex_rd,
               ex_redirect, ex_mdu_start, mdu_done, mem_req, mem_ack,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, pc_sel
    );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter for performance monitoring. Sticks at all-ones
// instead of wrapping. W must be at least 2.
//   clk_i : clock
//   rst_n : synchronous active-low reset, clears the count
//   inc   : count this cycle
//   cnt   : current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] cnt_r;

    // Count register: clear on reset, increment until all-ones then hold.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline sequencing controller for the 5-stage RV32I core. Owns every
// pipeline-register enable and flush and resolves memory wait states,
// branch/jump redirects, multi-cycle MUL/DIV stalls and load-use bubbles.
// Controls are combinational from state + inputs; state and counters are
// registered.
//   clk_i     : core clock
//   rst_n     : synchronous active-low reset
//   bus       : hazard status in / pipeline controls out (pipe_ctrl_if.slave)
//   stall_cnt : saturating count of cycles with pc_en low (outside reset)
//   flush_cnt : saturating count of accepted redirects
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    pipe_ctrl_if.slave       bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_state_t state_r;
    ctrl_state_t state_nxt_s;
    ctrl_state_t run_next_s;
    ctrl_out_t   ctrl_s;
    ctrl_out_t   run_ctrl_s;
    logic        run_redirect_s;
    logic        redirect_acc_s;
    logic        load_use_s;
    logic        mem_wait_s;
    logic        stall_inc_s;
    logic        flush_inc_s;

    assign load_use_s = load_use_hazard(bus.ex_is_load, bus.ex_rd, bus.id_rs1,
                                        bus.id_rs2, bus.id_use_rs1, bus.id_use_rs2);

    // An ack arriving with the request costs nothing; only an unacked request stalls.
    assign mem_wait_s = bus.mem_req && !bus.mem_ack;

    // State register; reset abandons any outstanding wait.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_r <= S_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Redirect > MDU start > load-use > go, shared by S_RUN and the S_MEMW ack cycle.
    always_comb begin
        run_ctrl_s     = CTRL_GO;
        run_next_s     = S_RUN;
        run_redirect_s = 1'b0;
        if (bus.ex_redirect) begin
            // The ID instruction is squashed, so a coincident load-use is moot.
            run_ctrl_s     = CTRL_REDIRECT;
            run_redirect_s = 1'b1;
        end else if (bus.ex_mdu_start) begin
            run_ctrl_s = CTRL_MDU;
            run_next_s = S_MDUW;
        end else if (load_use_s) begin
            run_ctrl_s = CTRL_LOAD_USE;
        end else begin
            run_ctrl_s = CTRL_GO;
        end
    end

    // Next state and pipeline controls from the current state.
    always_comb begin
        ctrl_s         = CTRL_HOLD;
        state_nxt_s    = state_r;
        redirect_acc_s = 1'b0;
        if (!rst_n) begin
            ctrl_s      = CTRL_RESET;
            state_nxt_s = S_RUN;
        end else begin
            case (state_r)
                S_RUN: begin
                    if (mem_wait_s) begin
                        ctrl_s      = CTRL_HOLD;
                        state_nxt_s = S_MEMW;
                    end else begin
                        ctrl_s         = run_ctrl_s;
                        state_nxt_s    = run_next_s;
                        redirect_acc_s = run_redirect_s;
                    end
                end
                S_MEMW: begin
                    if (bus.mem_ack) begin
                        ctrl_s         = run_ctrl_s;
                        state_nxt_s    = run_next_s;
                        redirect_acc_s = run_redirect_s;
                    end else begin
                        ctrl_s      = CTRL_HOLD;
                        state_nxt_s = S_MEMW;
                    end
                end
                S_MDUW: begin
                    // MEM holds a bubble here, so memory handshakes are ignored.
                    if (bus.mdu_done) begin
                        ctrl_s      = CTRL_GO;
                        state_nxt_s = S_RUN;
                    end else begin
                        ctrl_s      = CTRL_MDU;
                        state_nxt_s = S_MDUW;
                    end
                end
                default: begin
                    ctrl_s      = CTRL_HOLD;
                    state_nxt_s = S_RUN;
                end
            endcase
        end
    end

    assign bus.pc_en        = ctrl_s.pc_en;
    assign bus.if_id_en     = ctrl_s.if_id_en;
    assign bus.id_ex_en     = ctrl_s.id_ex_en;
    assign bus.ex_mem_en    = ctrl_s.ex_mem_en;
    assign bus.mem_wb_en    = ctrl_s.mem_wb_en;
    assign bus.if_id_flush  = ctrl_s.if_id_flush;
    assign bus.id_ex_flush  = ctrl_s.id_ex_flush;
    assign bus.ex_mem_flush = ctrl_s.ex_mem_flush;
    assign bus.pc_sel       = ctrl_s.pc_sel;

    assign stall_inc_s = rst_n && !ctrl_s.pc_en;
    assign flush_inc_s = rst_n && redirect_acc_s;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .inc   (stall_inc_s),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .inc   (flush_inc_s),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl. Two instances share the stimulus: a
// 32-bit counter build and a 4-bit counter build for saturation. Expected
// controls come from a directed vector table, hand sequences with fixed
// expected counts, and a rule-based reference model under random stimulus.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_i = ~clk_i;

    pipe_ctrl_if bus ();
    pipe_ctrl_if bus4 ();

    logic [31:0] stall_cnt, flush_cnt;
    logic [3:0]  stall_cnt4, flush_cnt4;

    pipe_ctrl #(.CNT_W(32)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .bus(bus),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) dut4 (
        .clk_i(clk_i), .rst_n(rst_n), .bus(bus4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    assign bus4.id_rs1       = bus.id_rs1;
    assign bus4.id_rs2       = bus.id_rs2;
    assign bus4.id_use_rs1   = bus.id_use_rs1;
    assign bus4.id_use_rs2   = bus.id_use_rs2;
    assign bus4.ex_is_load   = bus.ex_is_load;
    assign bus4.ex_rd        = bus.ex_rd;
    assign bus4.ex_redirect  = bus.ex_redirect;
    assign bus4.ex_mdu_start = bus.ex_mdu_start;
    assign bus4.mdu_done     = bus.mdu_done;
    assign bus4.mem_req      = bus.mem_req;
    assign bus4.mem_ack      = bus.mem_ack;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic       ld;
        logic [4:0] rd;
        logic       redir;
        logic       mdu_start;
        logic       mdu_done;
        logic       req;
        logic       ack;
    } in_t;

    typedef struct {
        string      name;
        in_t        v;
        logic [8:0] exp;
    } vec_t;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush, pc_sel}
    localparam logic [8:0] E_GO    = 9'b11111_000_0;
    localparam logic [8:0] E_HOLD  = 9'b00000_000_0;
    localparam logic [8:0] E_LU    = 9'b00111_010_0;
    localparam logic [8:0] E_REDIR = 9'b11111_110_1;
    localparam logic [8:0] E_MDU   = 9'b00001_001_0;
    localparam logic [8:0] E_RST   = 9'b00000_111_0;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: which wait (if any) the pipeline is in, and event counts.
    bit m_mem = 1'b0;
    bit m_mdu = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    function automatic logic [8:0] outs();
        return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.pc_sel};
    endfunction

    function automatic logic [8:0] outs4();
        return {bus4.pc_en, bus4.if_id_en, bus4.id_ex_en, bus4.ex_mem_en, bus4.mem_wb_en,
                bus4.if_id_flush, bus4.id_ex_flush, bus4.ex_mem_flush, bus4.pc_sel};
    endfunction

    function automatic logic [3:0] sat4(input int x);
        return (x > 15) ? 4'd15 : x[3:0];
    endfunction

    task automatic drive(input in_t v);
        bus.id_rs1 = v.rs1;        bus.id_rs2 = v.rs2;
        bus.id_use_rs1 = v.use1;   bus.id_use_rs2 = v.use2;
        bus.ex_is_load = v.ld;     bus.ex_rd = v.rd;
        bus.ex_redirect = v.redir; bus.ex_mdu_start = v.mdu_start;
        bus.mdu_done = v.mdu_done; bus.mem_req = v.req;
        bus.mem_ack = v.ack;
    endtask

    // Behavioural rules: what the pipeline must do this cycle and where it goes next.
    task automatic model(input in_t v, output logic [8:0] e, output bit n_mem,
                         output bit n_mdu, output bit took);
        bit hazard;
        took  = 1'b0;
        n_mem = m_mem;
        n_mdu = m_mdu;
        hazard = v.ld && (v.rd != 5'd0) &&
                 ((v.use1 && v.rs1 == v.rd) || (v.use2 && v.rs2 == v.rd));
        if (!rst_n) begin
            e = E_RST; n_mem = 1'b0; n_mdu = 1'b0;
        end else if (m_mdu) begin
            e = v.mdu_done ? E_GO : E_MDU;
            n_mdu = !v.mdu_done;
        end else if (m_mem && !v.ack) begin
            e = E_HOLD;
        end else if (!m_mem && v.req && !v.ack) begin
            e = E_HOLD; n_mem = 1'b1;
        end else begin
            n_mem = 1'b0;
            if (v.redir) begin
                e = E_REDIR; took = 1'b1;
            end else if (v.mdu_start) begin
                e = E_MDU; n_mdu = 1'b1;
            end else if (hazard) begin
                e = E_LU;
            end else begin
                e = E_GO;
            end
        end
    endtask

    // One clock cycle: apply inputs, check controls, clock, check counters.
    task automatic step(input in_t v, input string nm, input bit has_exp, input logic [8:0] texp);
        logic [8:0] e;
        bit nmem, nmdu, took;
        drive(v);
        #1;
        model(v, e, nmem, nmdu, took);
        chk({nm, "_ctrl"}, {23'd0, outs()}, {23'd0, has_exp ? texp : e});
        chk({nm, "_ctrl4"}, {23'd0, outs4()}, {23'd0, has_exp ? texp : e});
        @(posedge clk_i);
        #1;
        if (rst_n) begin
            if (!e[8]) m_stall++;
            if (took) m_flush++;
        end else begin
            m_stall = 0;
            m_flush = 0;
        end
        m_mem = nmem;
        m_mdu = nmdu;
        chk({nm, "_stall"}, stall_cnt, m_stall);
        chk({nm, "_flush"}, flush_cnt, m_flush);
        chk({nm, "_stall4"}, {28'd0, stall_cnt4}, {28'd0, sat4(m_stall)});
        chk({nm, "_flush4"}, {28'd0, flush_cnt4}, {28'd0, sat4(m_flush)});
    endtask

    task automatic do_reset();
        in_t z;
        z = '0;
        rst_n = 1'b0;
        step(z, "rst", 1'b1, E_RST);
        rst_n = 1'b1;
    endtask

    vec_t tab[10];

    initial begin
        in_t z, v;
        z = '0;

        // Vectors applied one per cycle from S_RUN.
        tab[0] = '{"idle", z, E_GO};
        v = z; v.ld = 1'b1; v.rd = 5'd5; v.rs2 = 5'd5; v.use2 = 1'b1;
        tab[1] = '{"lu_rs2", v, E_LU};
        v = z; v.ld = 1'b1; v.rd = 5'd7; v.rs1 = 5'd7; v.use1 = 1'b1;
        tab[2] = '{"lu_rs1", v, E_LU};
        v = z; v.ld = 1'b1; v.rd = 5'd0; v.rs1 = 5'd0; v.use1 = 1'b1;
        tab[3] = '{"ld_x0", v, E_GO};
        v = z; v.ld = 1'b1; v.rd = 5'd5; v.rs2 = 5'd5; v.use2 = 1'b0;
        tab[4] = '{"ld_nouse", v, E_GO};
        v = z; v.redir = 1'b1;
        tab[5] = '{"redir", v, E_REDIR};
        v = z; v.redir = 1'b1; v.ld = 1'b1; v.rd = 5'd5; v.rs2 = 5'd5; v.use2 = 1'b1;
        tab[6] = '{"redir_lu", v, E_REDIR};
        v = z; v.ack = 1'b1;
        tab[7] = '{"ack_noreq", v, E_GO};
        v = z; v.mdu_done = 1'b1;
        tab[8] = '{"done_run", v, E_GO};
        v = z; v.ld = 1'b0; v.rd = 5'd5; v.rs1 = 5'd5; v.use1 = 1'b1;
        tab[9] = '{"noload", v, E_GO};

        // Reset: combinational controls, then cleared counters.
        drive(z);
        #1;
        chk("reset_ctrl", {23'd0, outs()}, {23'd0, E_RST});
        @(posedge clk_i);
        #1;
        chk("reset_stall", stall_cnt, 32'd0);
        chk("reset_flush", flush_cnt, 32'd0);
        do_reset();

        for (int i = 0; i < 10; i++) step(tab[i].v, tab[i].name, 1'b1, tab[i].exp);
        chk("tab_stall", stall_cnt, 32'd2);
        chk("tab_flush", flush_cnt, 32'd2);

        // Load-use: one bubble, then free running.
        do_reset();
        step(tab[1].v, "seq_lu", 1'b1, E_LU);
        step(z, "seq_lu_after", 1'b1, E_GO);
        chk("lu_stall_total", stall_cnt, 32'd1);

        // Redirect beats a coincident load-use.
        do_reset();
        step(tab[6].v, "seq_redir_lu", 1'b1, E_REDIR);
        chk("redir_lu_flush", flush_cnt, 32'd1);
        chk("redir_lu_stall", stall_cnt, 32'd0);

        // MUL/DIV: start, done 33 cycles later.
        do_reset();
        v = z; v.mdu_start = 1'b1;
        step(v, "mdu_start", 1'b1, E_MDU);
        for (int i = 0; i < 32; i++) step(z, "mdu_wait", 1'b1, E_MDU);
        v = z; v.mdu_done = 1'b1;
        step(v, "mdu_done", 1'b1, E_GO);
        chk("mdu_stall_total", stall_cnt, 32'd33);
        step(tab[1].v, "mdu_back_run", 1'b1, E_LU);

        // Memory wait: request held 3 cycles, ack in the 4th.
        do_reset();
        v = z; v.req = 1'b1;
        for (int i = 0; i < 3; i++) step(v, "mem_wait", 1'b1, E_HOLD);
        v.ack = 1'b1;
        step(v, "mem_ack", 1'b1, E_GO);
        chk("mem_stall_total", stall_cnt, 32'd3);

        // Saturation and reset in the middle of an MDU wait.
        do_reset();
        v = z; v.mdu_start = 1'b1;
        step(v, "sat_start", 1'b1, E_MDU);
        for (int i = 0; i < 19; i++) step(z, "sat_wait", 1'b1, E_MDU);
        chk("sat_stall4", {28'd0, stall_cnt4}, 32'd15);
        chk("sat_stall32", stall_cnt, 32'd20);
        do_reset();
        chk("midwait_rst_stall", stall_cnt, 32'd0);
        chk("midwait_rst_stall4", {28'd0, stall_cnt4}, 32'd0);
        step(z, "midwait_back_run", 1'b1, E_GO);

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            v.rs1       = 5'($urandom_range(0, 3));
            v.rs2       = 5'($urandom_range(0, 3));
            v.rd        = 5'($urandom_range(0, 3));
            v.use1      = 1'($urandom_range(0, 1));
            v.use2      = 1'($urandom_range(0, 1));
            v.ld        = 1'($urandom_range(0, 1));
            v.redir     = ($urandom_range(0, 7) == 0);
            v.mdu_start = ($urandom_range(0, 9) == 0);
            v.mdu_done  = ($urandom_range(0, 3) == 0);
            v.req       = m_mem ? 1'b1 : ($urandom_range(0, 4) == 0);
            v.ack       = 1'($urandom_range(0, 1));
            rst_n       = ($urandom_range(0, 99) != 0);
            step(v, "rand", 1'b0, E_GO);
        end
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage RV32I core. It sits beside the forwarding unit and owns every pipeline-register enable and flush. It resolves four hazards: load-use bubbles, branch/jump redirect flushes, multi-cycle MUL/DIV stalls and data-memory wait states. It also keeps saturating stall and flush counters for performance monitoring.

## Interface
- CNT_W, 32, width of the performance counters.

- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1 / rs2.
- ex_is_load  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the EX instruction.
- ex_redirect  in  1  EX resolved a taken branch or jump that changes the PC.
- ex_mdu_start  in  1  EX holds a MUL/DIV that is entering the multi-cycle unit.
- mdu_done  in  1  MUL/DIV result valid this cycle.
- mem_req  in  1  MEM stage has an outstanding load or store.
- mem_ack  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble (NOP, write-enables cleared).
- pc_sel  out  1  PC takes the EX redirect target.
- stall_cnt  out  CNT_W  cycles with pc_en=0, rst_n high.
- flush_cnt  out  CNT_W  redirects accepted.

## Operation
- FSM states:
  - S_RUN: normal operation.
  - S_MEMW: waiting for the memory acknowledge.
  - S_MDUW: waiting for the MUL/DIV result.
- Control outputs are combinational from the current state and inputs. State and counters are registered.
- Priority in S_RUN, highest first:
  1. **Memory wait** (mem_req & ~mem_ack): all five enables 0, no flushes. Next state is S_MEMW.
  2. **Redirect** (ex_redirect): pc_sel=1, if_id_flush=1, id_ex_flush=1, all enables 1. flush_cnt increments.
  3. **MDU start** (ex_mdu_start): pc_en, if_id_en, id_ex_en and ex_mem_en are 0; ex_mem_flush=1; mem_wb_en=1. Next state is S_MDUW.
  4. **Load-use**: fires when ex_is_load, ex_rd≠0, and the ID instruction reads ex_rd (id_use_rs1 with id_rs1==ex_rd, or id_use_rs2 with id_rs2==ex_rd). Response: pc_en=0, if_id_en=0, id_ex_flush=1, remaining enables 1. No state change; exactly one bubble.
  5. **Otherwise**: all enables 1, no flushes, pc_sel=0.
- S_MEMW:
  - Without mem_ack: all enables 0.
  - On mem_ack: all enables 1 and return to S_RUN. Redirect, MDU and load-use are evaluated as in S_RUN in that same cycle.
- S_MDUW:
  - Without mdu_done: same outputs as the MDU start cycle.
  - On mdu_done: all enables 1, no flushes, return to S_RUN.
  - mem_req/mem_ack are ignored in this state; MEM holds a bubble.
- Ignored inputs: mdu_done in S_RUN/S_MEMW and mem_ack without mem_req.
- Counters: saturate at all-ones, never wrap. stall_cnt counts every cycle with pc_en=0.
- Reset (rst_n=0 at an edge): state S_RUN, stall_cnt=0, flush_cnt=0.
  - While rst_n=0, combinationally: all enables 0, all flushes 1, pc_sel=0. Counters do not increment.
  - Reset asserted mid-S_MEMW or mid-S_MDUW abandons the wait; no ack is required.

## Timing
- Enable, flush and pc_sel responses take effect in the same cycle as the causing inputs.
- Counters show the increment one cycle after the event.
- Load-use costs exactly 1 stall cycle. The load moves to MEM and the forwarding unit supplies the data.
- An MDU operation taking N cycles until mdu_done costs N stall cycles. A same-cycle mdu_done is not allowed; the earliest legal done is one cycle after start.
- A memory access acknowledged k cycles after mem_req rises costs k stall cycles. An ack in the request cycle costs 0.
- A redirect in the same cycle as a load-use: redirect wins, since the ID instruction is flushed, and stall_cnt does not increment.

## Structure
- pipe_ctrl_pkg holds:
  - typedef enum logic [1:0] ctrl_state_t {S_RUN, S_MEMW, S_MDUW};
  - localparam REG_ZERO = 5'd0.
- One sub-module: sat_counter (parameter W; inputs clk_i, rst_n, inc; output cnt), instantiated twice.

## Test plan
- **Load-use:** ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables 1; stall_cnt=1.
- **Load, no use:** ex_rd=0, or ex_rd=5 with id_use_rs2=0 → no stall.
- **Redirect vs load-use:** ex_redirect and a load-use hazard in the same cycle → pc_sel=1, if_id_flush=id_ex_flush=1, pc_en=1; flush_cnt=1, stall_cnt=0.
- **MDU:** ex_mdu_start, then mdu_done 33 cycles later → 33 cycles with ex_mem_flush=1 and mem_wb_en=1; FSM back in S_RUN; stall_cnt=33.
- **Memory wait:** mem_req held 3 cycles, mem_ack in the 4th → enables 0 for 3 cycles, 1 in the ack cycle; stall_cnt=3.
- **Reset mid-wait:** rst_n=0 during S_MDUW → next cycle in S_RUN with counters 0. With CNT_W=4 and 20 stall cycles, stall_cnt stays at 15.
